// File: rtl/seq_gen_if.sv
// Handshake bundle between the pattern generator and its pattern detector.
// The master side drives requests and detector returns; the slave side is the generator.
interface seq_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len_hi;
  logic [CNT_W-1:0] len_lo;
  logic             K1;
  logic             K2;
  logic             A;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, len_hi, len_lo, K1, K2,
    input  A, busy, done, err
  );

  modport slave (
    input  start, len_hi, len_lo, K1, K2,
    output A, busy, done, err
  );
endinterface

// File: rtl/seq_gen.sv
// Emits a HI/LO/HI/LO pattern on A with programmable dwell lengths and checks
// the detector's K1/K2 return pulses against the pattern, flagging mismatches in err.
module seq_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_gen_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHi1, StLo1, StHi2, StLo2, StFin} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_hi_q, len_hi_d;
  logic [CNT_W-1:0] len_lo_q, len_lo_d;
  logic             first_q, first_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             k1_exp, k2_exp;

  // Counter load value for a phase: a zero length behaves as a one-cycle dwell.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CntOne;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_hi_d = len_hi_q;
    len_lo_d = len_lo_q;
    first_d  = 1'b0;
    err_d    = err_q;
    k1_exp   = 1'b0;
    k2_exp   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_hi_d = bus.len_hi;
          len_lo_d = bus.len_lo;
          err_d    = 1'b0;
          state_d  = StHi1;
          cnt_d    = load_val(bus.len_hi);
          first_d  = 1'b1;
        end
      end
      StHi1, StLo1, StHi2, StLo2: begin
        // Only the first cycle of HI2 / LO2 may carry a return pulse.
        k2_exp = first_q && (state_q == StHi2);
        k1_exp = first_q && (state_q == StLo2);
        if ((bus.K1 != k1_exp) || (bus.K2 != k2_exp)) begin
          err_d = 1'b1;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          first_d = 1'b1;
          unique case (state_q)
            StHi1: begin
              state_d = StLo1;
              cnt_d   = load_val(len_lo_q);
            end
            StLo1: begin
              state_d = StHi2;
              cnt_d   = load_val(len_hi_q);
            end
            StHi2: begin
              state_d = StLo2;
              cnt_d   = load_val(len_lo_q);
            end
            default: begin
              state_d = StFin;
              cnt_d   = '0;
              first_d = 1'b0;
            end
          endcase
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    a_d    = (state_d == StHi1) || (state_d == StHi2);
    busy_d = (state_d == StHi1) || (state_d == StLo1) ||
             (state_d == StHi2) || (state_d == StLo2);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_hi_q <= '0;
      len_lo_q <= '0;
      first_q  <= 1'b0;
      a_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_hi_q <= len_hi_d;
      len_lo_q <= len_lo_d;
      first_q  <= first_d;
      a_q      <= a_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: drives patterns with a scripted detector and
// checks A/busy/done/err cycle by cycle against hand-computed schedules.
module tb_seq_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_gen_if #(.CNT_W(8)) bus ();

  seq_gen #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c=1 is the cycle after the accepted start. exp_a bit (c-1) is A in cycle c.
  // k2_c/k1_c/k1_bad: cycles in which the detector drives K2/K1 (0 = never).
  // err_from: first cycle err is expected high (0 = never); restart_c: cycle to re-pulse start.
  task automatic run(input logic [7:0] hi, input logic [7:0] lo, input int n_busy,
                     input logic [31:0] exp_a, input int k2_c, input int k1_c,
                     input int k1_bad, input int err_from, input int restart_c);
    bus.len_hi = hi;
    bus.len_lo = lo;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.len_hi = 8'h0f;
    bus.len_lo = 8'h0f;
    for (int c = 1; c <= n_busy + 1; c++) begin
      chk($sformatf("A c%0d", c), {31'd0, bus.A}, (c <= n_busy) ? {31'd0, exp_a[c-1]} : 32'd0);
      chk($sformatf("busy c%0d", c), {31'd0, bus.busy}, {31'd0, (c <= n_busy)});
      chk($sformatf("done c%0d", c), {31'd0, bus.done}, {31'd0, (c == n_busy + 1)});
      chk($sformatf("err c%0d", c), {31'd0, bus.err}, {31'd0, (err_from != 0 && c >= err_from)});
      bus.K1 = (c == k1_c) || (c == k1_bad);
      bus.K2 = (c == k2_c);
      if (c == restart_c) begin
        bus.start  = 1'b1;
        bus.len_hi = 8'd7;
        bus.len_lo = 8'd7;
      end
      tick();
      bus.K1    = 1'b0;
      bus.K2    = 1'b0;
      bus.start = 1'b0;
    end
    chk("idle done", {31'd0, bus.done}, 32'd0);
    chk("idle busy", {31'd0, bus.busy}, 32'd0);
    chk("idle err", {31'd0, bus.err}, {31'd0, (err_from != 0)});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    bus.start  = 1'b1;
    bus.len_hi = 8'd5;
    bus.len_lo = 8'd5;
    bus.K1     = 1'b0;
    bus.K2     = 1'b0;

    // Reset held with start asserted: reset wins.
    tick();
    tick();
    chk("rst A", {31'd0, bus.A}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst err", {31'd0, bus.err}, 32'd0);
    bus.start = 1'b0;
    rst       = 1'b1;
    tick();
    chk("post-rst busy", {31'd0, bus.busy}, 32'd0);

    // Clean 3/2 pattern: A = 1,1,1,0,0,1,1,1,0,0; done in cycle 11.
    run(8'd3, 8'd2, 10, 32'b0011100111, 6, 9, 0, 0, 0);
    // Zero lengths act as 1: A = 1,0,1,0; done in cycle 5.
    run(8'd0, 8'd0, 4, 32'b0101, 3, 4, 0, 0, 0);
    // Missing K2 at HI2 entry (cycle 5): err from cycle 6, sticky in idle.
    run(8'd2, 8'd2, 8, 32'b00110011, 0, 7, 0, 6, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err sticky", {31'd0, bus.err}, 32'd1);
    end
    // Stray K1 in LO1 second cycle (cycle 5): err from cycle 6.
    run(8'd3, 8'd2, 10, 32'b0011100111, 6, 9, 5, 6, 0);
    // Clean run clears err on acceptance.
    run(8'd3, 8'd2, 10, 32'b0011100111, 6, 9, 0, 0, 0);
    // Start re-pulsed during HI2 with other lengths: ignored.
    run(8'd3, 8'd2, 10, 32'b0011100111, 6, 9, 0, 0, 7);

    // Reset during LO1 aborts the pattern without a done pulse.
    bus.len_hi = 8'd3;
    bus.len_lo = 8'd2;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-abort A", {31'd0, bus.A}, 32'd0);
    chk("pre-abort busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort A", {31'd0, bus.A}, 32'd0);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort err", {31'd0, bus.err}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no done after abort", {31'd0, bus.done}, 32'd0);
      chk("idle after abort", {31'd0, bus.busy}, 32'd0);
    end
    run(8'd3, 8'd2, 10, 32'b0011100111, 6, 9, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
